// File: rtl/comparator_serial_nb.sv
// Bit-serial, MSB-first magnitude comparator with start/busy/done handshake.
// Handles unsigned or two's-complement operands, selected per operation.
module comparator_serial_nb #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       signed_mode,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  output logic                       busy,
  output logic                       done,
  output logic                       A_great_B,
  output logic                       A_equal_B,
  output logic                       A_less_B,
  output logic [$clog2(WIDTH+1)-1:0] bit_count
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [IW-1:0]    idx;
  logic             signed_r;
  logic             decided;
  logic             dec_great;

  logic a_bit, b_bit, diff, at_msb, great_bit;
  logic res_diff, res_great, finish;

  assign busy = (state == SHIFT);

  // NOTE: every combinational output gets a default first, so no path
  // through the block leaves a variable unassigned and infers a latch.
  always_comb begin
    a_bit      = sh_a[WIDTH-1];
    b_bit      = sh_b[WIDTH-1];
    diff       = a_bit ^ b_bit;
    at_msb     = (idx == IW'(WIDTH - 1));
    // In signed mode a set sign bit means the smaller value.
    great_bit  = (signed_r && at_msb) ? ~a_bit : a_bit;
    res_diff   = decided | diff;
    res_great  = decided ? dec_great : great_bit;
    finish     = (state == SHIFT) && ((idx == '0) || (EARLY_EXIT && diff));
    state_next = state;
    case (state)
      IDLE:    if (start)  state_next = SHIFT;
      SHIFT:   if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shift registers are reset too, so an aborted operation
      // leaves no stale operand bits behind.
      state     <= IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      idx       <= '0;
      signed_r  <= 1'b0;
      decided   <= 1'b0;
      dec_great <= 1'b0;
      done      <= 1'b0;
      A_great_B <= 1'b0;
      A_equal_B <= 1'b0;
      A_less_B  <= 1'b0;
      bit_count <= '0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a      <= a;
            sh_b      <= b;
            signed_r  <= signed_mode;
            decided   <= 1'b0;
            dec_great <= 1'b0;
            idx       <= IW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          sh_a <= {sh_a[WIDTH-2:0], 1'b0};
          sh_b <= {sh_b[WIDTH-2:0], 1'b0};
          idx  <= idx - 1'b1;
          // Only the first differing bit decides; later bits are ignored.
          if (diff && !decided) begin
            decided   <= 1'b1;
            dec_great <= great_bit;
          end
          if (finish) begin
            A_great_B <= res_diff & res_great;
            A_less_B  <= res_diff & ~res_great;
            A_equal_B <= ~res_diff;
            bit_count <= CW'(WIDTH) - CW'(idx);
            done      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_comparator_serial_nb.sv
// Self-checking bench for comparator_serial_nb: one early-exit and one
// full-scan instance, table vectors, random ops, back-to-back and reset abort.
module tb_comparator_serial_nb;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);

  typedef struct {
    logic [2:0] fl;  // {great, equal, less}
    int         k;
  } exp_t;

  typedef struct {
    int         d;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       sm;
    logic [2:0] fl;
    int         k;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          start0, start1;
  logic          sm;
  logic [W-1:0]  a, b;
  logic          busy_s [2];
  logic          done_s [2];
  logic          gt_s   [2];
  logic          eq_s   [2];
  logic          lt_s   [2];
  logic [CW-1:0] bc_s   [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];
  int   bcyc     [2];
  logic prev_done[2];
  logic [2:0]    last_fl [2];
  logic [CW-1:0] last_bc [2];
  int   done_cnt [2];

  comparator_serial_nb #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(sm), .a(a), .b(b),
    .busy(busy_s[0]), .done(done_s[0]), .A_great_B(gt_s[0]),
    .A_equal_B(eq_s[0]), .A_less_B(lt_s[0]), .bit_count(bc_s[0])
  );

  comparator_serial_nb #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(sm), .a(a), .b(b),
    .busy(busy_s[1]), .done(done_s[1]), .A_great_B(gt_s[1]),
    .A_equal_B(eq_s[1]), .A_less_B(lt_s[1]), .bit_count(bc_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic s, input logic ee);
    exp_t e;
    int   k;
    logic found;
    logic gt, lt;
    k = W;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && (x[i] != y[i])) begin
        found = 1'b1;
        k = W - i;
      end
    end
    if (!ee) k = W;
    if (s) begin
      gt = $signed(x) > $signed(y);
      lt = $signed(x) < $signed(y);
    end else begin
      gt = x > y;
      lt = x < y;
    end
    e.fl = {gt, (x == y), lt};
    e.k  = k;
    return e;
  endfunction

  task automatic monitor(input int d);
    logic [2:0] fl;
    exp_t       e;
    fl = {gt_s[d], eq_s[d], lt_s[d]};
    if (rst) begin
      bcyc[d]      = 0;
      prev_done[d] = 1'b0;
      last_fl[d]   = '0;
      last_bc[d]   = '0;
      return;
    end
    if (busy_s[d]) bcyc[d]++;
    if (done_s[d]) begin
      check($sformatf("d%0d_done_one_cycle", d), 32'(prev_done[d]), 32'd0);
      check($sformatf("d%0d_busy_low_at_done", d), 32'(busy_s[d]), 32'd0);
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        check($sformatf("d%0d_spurious_done", d), 32'd1, 32'd0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("d%0d_flags", d), 32'(fl), 32'(e.fl));
        check($sformatf("d%0d_bit_count", d), 32'(bc_s[d]), 32'(e.k));
        check($sformatf("d%0d_busy_cycles", d), 32'(bcyc[d]), 32'(e.k));
        last_fl[d] = e.fl;
        last_bc[d] = CW'(e.k);
      end
      bcyc[d] = 0;
      done_cnt[d]++;
    end else begin
      check($sformatf("d%0d_flags_hold", d), 32'(fl), 32'(last_fl[d]));
      check($sformatf("d%0d_bit_count_hold", d), 32'(bc_s[d]), 32'(last_bc[d]));
    end
    prev_done[d] = done_s[d];
  endtask

  task automatic tick();
    @(negedge clk);
    monitor(0);
    monitor(1);
  endtask

  task automatic run_op(input int d, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xs, input exp_t e);
    int target, guard;
    a  = xa;
    b  = xb;
    sm = xs;
    if (d == 0) begin start0 = 1'b1; q0.push_back(e); end
    else        begin start1 = 1'b1; q1.push_back(e); end
    target = done_cnt[d] + 1;
    tick();
    start0 = 1'b0;
    start1 = 1'b0;
    a  = W'($urandom);
    b  = W'($urandom);
    sm = 1'($urandom);
    guard = 0;
    while (done_cnt[d] < target && guard < 40) begin
      tick();
      guard++;
    end
    check($sformatf("d%0d_op_completed", d), 32'(done_cnt[d] >= target), 32'd1);
  endtask

  vec_t vecs[12];

  initial begin
    int   ops, issued, base, guard;
    logic expect_busy;
    exp_t e;

    vecs[0]  = '{0, 8'h5A, 8'h5A, 1'b0, 3'b010, 8};
    vecs[1]  = '{0, 8'h80, 8'h7F, 1'b0, 3'b100, 1};
    vecs[2]  = '{0, 8'h80, 8'h7F, 1'b1, 3'b001, 1};
    vecs[3]  = '{0, 8'h10, 8'h18, 1'b0, 3'b001, 5};
    vecs[4]  = '{0, 8'h03, 8'h02, 1'b0, 3'b100, 8};
    vecs[5]  = '{0, 8'h7F, 8'h80, 1'b1, 3'b100, 1};
    vecs[6]  = '{0, 8'hFE, 8'hFF, 1'b1, 3'b001, 8};
    vecs[7]  = '{0, 8'hFF, 8'hFF, 1'b1, 3'b010, 8};
    vecs[8]  = '{1, 8'h80, 8'h7F, 1'b0, 3'b100, 8};
    vecs[9]  = '{1, 8'hFF, 8'h01, 1'b1, 3'b001, 8};
    vecs[10] = '{1, 8'h10, 8'h18, 1'b0, 3'b001, 8};
    vecs[11] = '{1, 8'h00, 8'h00, 1'b0, 3'b010, 8};

    for (int d = 0; d < 2; d++) begin
      bcyc[d] = 0; prev_done[d] = 1'b0; last_fl[d] = '0; last_bc[d] = '0; done_cnt[d] = 0;
    end
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; sm = 1'b0; a = '0; b = '0;
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_busy", d), 32'(busy_s[d]), 32'd0);
      check($sformatf("d%0d_rst_done", d), 32'(done_s[d]), 32'd0);
      check($sformatf("d%0d_rst_flags", d), 32'({gt_s[d], eq_s[d], lt_s[d]}), 32'd0);
      check($sformatf("d%0d_rst_bit_count", d), 32'(bc_s[d]), 32'd0);
    end
    rst = 1'b0;
    tick();

    // Directed vectors with hand-derived results.
    for (int i = 0; i < 12; i++) begin
      e.fl = vecs[i].fl;
      e.k  = vecs[i].k;
      run_op(vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].sm, e);
      tick();
    end

    // Random operations on both instances, some with equal operands.
    for (int i = 0; i < 20; i++) begin
      int   d;
      logic [W-1:0] xa, xb;
      logic xs;
      d  = i % 2;
      xa = W'($urandom);
      xb = ($urandom_range(0, 3) == 0) ? xa : W'($urandom);
      xs = 1'($urandom);
      run_op(d, xa, xb, xs, model(xa, xb, xs, (d == 0)));
    end

    // Back-to-back: start held high, operands scrambled while busy.
    ops = 6;
    base = done_cnt[0];
    a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
    q0.push_back(model(a, b, sm, 1'b1));
    issued = 1;
    start0 = 1'b1;
    expect_busy = 1'b0;
    guard = 0;
    while ((done_cnt[0] - base) < ops && guard < 400) begin
      tick();
      guard++;
      if (expect_busy) begin
        check("b2b_busy_after_done", 32'(busy_s[0]), 32'd1);
        expect_busy = 1'b0;
      end
      if (done_s[0]) begin
        if (issued < ops) begin
          a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
          if ($urandom_range(0, 2) == 0) b = a;
          q0.push_back(model(a, b, sm, 1'b1));
          issued++;
          expect_busy = 1'b1;
        end else begin
          start0 = 1'b0;
        end
      end else begin
        a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
      end
    end
    start0 = 1'b0;
    check("b2b_done_count", 32'(done_cnt[0] - base), 32'(ops));
    check("b2b_queue_empty", 32'(q0.size()), 32'd0);
    repeat (2) tick();

    // Reset on the 3rd SHIFT edge aborts the operation with no done pulse.
    check("pre_abort_flags_valid", 32'(gt_s[0] | eq_s[0] | lt_s[0]), 32'd1);
    a = 8'h01; b = 8'h00; sm = 1'b0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(busy_s[0]), 32'd0);
    check("abort_done", 32'(done_s[0]), 32'd0);
    check("abort_flags", 32'({gt_s[0], eq_s[0], lt_s[0]}), 32'd0);
    check("abort_bit_count", 32'(bc_s[0]), 32'd0);
    rst = 1'b0;
    base = done_cnt[0];
    repeat (12) tick();
    check("abort_no_done", 32'(done_cnt[0] - base), 32'd0);

    // A fresh operation after the abort still works.
    run_op(0, 8'h01, 8'h00, 1'b0, model(8'h01, 8'h00, 1'b0, 1'b1));
    tick();
    check("final_queue0_empty", 32'(q0.size()), 32'd0);
    check("final_queue1_empty", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
